pipe_mux_n: RTL

Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshaking on every input and on the output, for selecting between pipeline sources such as forwarded operands or writeback candidates. A select input chooses the active channel. The selected beat enters a two-entry skid buffer, which gives full throughput under backpressure. A flush input empties the buffer for branch/hazard recovery.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_skid_buf.sv | 67 ++++++
 rtl/pipe_mux_n.sv | 63 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipelined N-input mux: buffer occupancy state and
// the default channel slice width.
package pipe_pkg;

   localparam int CHAN_W = 32;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Handshake state machine and storage behind the mux: a head register
// plus an optional skid entry.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int WIDTH = CHAN_W,
   parameter int SKID  = 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             space,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output state_t           state
);

   // Handshake: a beat moves when valid && ready are both high at a rising
   // edge; push is already qualified by space, drain by out_valid.
   logic [WIDTH-1:0] skid_q;
   logic             drain;

   assign out_valid = (state != EMPTY);
   assign drain     = out_valid && out_ready;
   // With SKID=1, space only looks at state so in_ready never sees out_ready.
   assign space     = (SKID != 0) ? (state != TWO) : ((state == EMPTY) || out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         out_data <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  out_data <= push_data;
                  state    <= ONE;
               end
            end
            ONE: begin
               if (push && drain) begin
                  out_data <= push_data;
               end else if (push) begin
                  skid_q <= push_data;
                  state  <= TWO;
               end else if (drain) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (drain) begin
                  out_data <= skid_q;
                  state    <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/pipe_mux_n.sv
// N-input registered multiplexer: selects one valid/ready channel and feeds
// it into a skid buffer with flush.
module pipe_mux_n
   import pipe_pkg::*;
#(
   parameter int WIDTH = CHAN_W,
   parameter int N_IN  = 4,
   parameter int SKID  = 1,
   localparam int SEL_W = $clog2(N_IN)
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_IN*WIDTH-1:0]   in_data,
   input  logic [N_IN-1:0]         in_valid,
   output logic [N_IN-1:0]         in_ready,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              count,
   output logic                    sel_err
);

   logic             space;
   logic             accept;
   logic [WIDTH-1:0] sel_data;
   state_t           state;

   assign sel_err = (int'(sel) >= N_IN);

   // An out-of-range sel matches no channel, so every ready stays low.
   always_comb begin
      sel_data = '0;
      in_ready = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (int'(sel) == i) begin
            sel_data    = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = space && !flush && !rst;
         end
      end
   end

   assign accept = |(in_valid & in_ready);
   assign count  = state;

   pipe_skid_buf #(
      .WIDTH (WIDTH),
      .SKID  (SKID)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (accept),
      .push_data (sel_data),
      .space     (space),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state     (state)
   );

endmodule
